elixirchip_es1_spu_op_sll: RTL



---
 rtl/elixirchip_es1_spu_pkg.sv | 15 +
 rtl/elixirchip_es1_spu_op_sll_stage.sv | 54 +++++
 rtl/elixirchip_es1_spu_op_sll.sv | 79 +++++++
 3 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// elixirchip_es1_spu_pkg: shared helpers and device constants for the ES1 SPU op library
package elixirchip_es1_spu_pkg;
  localparam string DEVICE_RTL = "RTL";
  localparam string DEVICE_7SERIES = "7SERIES";
  localparam string DEVICE_ULTRASCALE = "ULTRASCALE";
  function automatic int stage_of_level(input int level, input int latency, input int shift_bits);
    return shift_bits == 0 ? 0 : (level * latency) / shift_bits;
  endfunction
  // First shift level mapped to a stage at or beyond `stage`; shift_bits when none is.
  function automatic int level_lo(input int stage, input int latency, input int shift_bits);
    for (int i = 0; i < shift_bits; i++)
      if (stage_of_level(i, latency, shift_bits) >= stage) return i;
    return shift_bits;
  endfunction
endpackage

// File: rtl/elixirchip_es1_spu_op_sll_stage.sv
// elixirchip_es1_spu_op_sll_stage: applies shift levels LO..HI, optionally registered
module elixirchip_es1_spu_op_sll_stage #(
  parameter int DATA_BITS = 32,
  parameter int SHIFT_BITS = 5,
  parameter int LO = 0,
  parameter int HI = -1,
  parameter bit REGISTERED = 1,
  parameter bit IMMEDIATE_SHIFT = 0,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic [SHIFT_BITS-1:0] s_shift,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [DATA_BITS-1:0]  m_data,
  output logic [SHIFT_BITS-1:0] m_shift,
  output logic                  m_clear,
  output logic                  m_valid
);
  logic [DATA_BITS-1:0] lvl [HI-LO+2];
  assign lvl[0] = s_data;
  for (genvar g = LO; g <= HI; g++) begin : g_lvl
    assign lvl[g-LO+1] = s_shift[g] ? lvl[g-LO] << (2 ** g) : lvl[g-LO];
  end
  if (REGISTERED) begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        m_data <= CLEAR_DATA;
        m_clear <= 1'b0;
        m_valid <= 1'b0;
      end else if (cke) begin
        m_data <= lvl[HI-LO+1];
        m_clear <= s_clear;
        m_valid <= s_valid;
      end
    end
    if (IMMEDIATE_SHIFT) begin : g_imm
      assign m_shift = s_shift;
    end else begin : g_pipe
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) m_shift <= '0;
        else if (cke) m_shift <= s_shift;
      end
    end
  end else begin : g_comb
    assign m_data = lvl[HI-LO+1];
    assign m_shift = s_shift;
    assign m_clear = s_clear;
    assign m_valid = s_valid;
  end
endmodule

// File: rtl/elixirchip_es1_spu_op_sll.sv
// elixirchip_es1_spu_op_sll: pipelined logical left shift with cke/clear/valid hold output
module elixirchip_es1_spu_op_sll
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DATA_BITS = 32,
  parameter type data_t = logic [DATA_BITS-1:0],
  parameter int MAX_SHIFT = DATA_BITS,
  parameter int SHIFT_BITS = $clog2(MAX_SHIFT),
  parameter type shift_t = logic [SHIFT_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter bit IMMEDIATE_SHIFT = 0,
  parameter bit IMMEDIATE_DATA = 0,
  parameter bit USE_CLEAR = 1,
  parameter bit USE_VALID = 1,
  parameter string DEVICE = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG = "false"
) (
  input  logic   reset,
  input  logic   clk,
  input  logic   cke,
  input  shift_t s_shift,
  input  data_t  s_data,
  input  logic   s_clear,
  input  logic   s_valid,
  output data_t  m_data
);
  localparam int N = LATENCY == 0 ? 1 : LATENCY;
  logic c0, v0;
  assign c0 = USE_CLEAR && s_clear;
  assign v0 = !USE_VALID || s_valid;
  // The last stage is combinational; its register is the hold/clear output register below.
  for (genvar g = 0; g < N; g++) begin : g_st
    data_t di, d;
    shift_t si, s;
    logic ci, vi, c, v;
    if (g == 0) begin : g_first
      assign di = s_data;
      assign si = s_shift;
      assign ci = c0;
      assign vi = v0;
    end else begin : g_next
      assign di = g_st[g-1].d;
      assign si = g_st[g-1].s;
      assign ci = g_st[g-1].c;
      assign vi = g_st[g-1].v;
    end
    elixirchip_es1_spu_op_sll_stage #(
      .DATA_BITS(DATA_BITS),
      .SHIFT_BITS(SHIFT_BITS),
      .LO(level_lo(g, LATENCY, SHIFT_BITS)),
      .HI(level_lo(g + 1, LATENCY, SHIFT_BITS) - 1),
      .REGISTERED(g < LATENCY - 1),
      .IMMEDIATE_SHIFT(IMMEDIATE_SHIFT),
      .CLEAR_DATA(CLEAR_DATA)
    ) u_stage (
      .reset(reset),
      .clk(clk),
      .cke(cke),
      .s_data(di),
      .s_shift(si),
      .s_clear(ci),
      .s_valid(vi),
      .m_data(d),
      .m_shift(s),
      .m_clear(c),
      .m_valid(v)
    );
  end
  if (LATENCY == 0) begin : g_comb_out
    assign m_data = g_st[N-1].c ? CLEAR_DATA : g_st[N-1].d;
  end else begin : g_reg_out
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) m_data <= CLEAR_DATA;
      else if (cke && (g_st[N-1].c || g_st[N-1].v)) m_data <= g_st[N-1].c ? CLEAR_DATA : g_st[N-1].d;
    end
  end
endmodule
